// File: rtl/mdio_master_if.sv
// MDIO master register-block interface: start strobe, command word and
// MDC ratio toward the master; read data, completion pulse and busy back.
interface mdio_master_if #(
    parameter int FRAMEWIDTH = 32,
    parameter int RATIOWIDTH = 8
);
    logic                  stb_mdiostart;
    logic [FRAMEWIDTH-1:0] mdiodatatx;
    logic [RATIOWIDTH-1:0] mdioclk4ratio;
    logic [15:0]           mdiodatarx;
    logic                  mdiorxvalid;
    logic                  busy;

    modport master (
        output stb_mdiostart,
        output mdiodatatx,
        output mdioclk4ratio,
        input  mdiodatarx,
        input  mdiorxvalid,
        input  busy
    );

    modport slave (
        input  stb_mdiostart,
        input  mdiodatatx,
        input  mdioclk4ratio,
        output mdiodatarx,
        output mdiorxvalid,
        output busy
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: preamble + 32-bit frame on MDC/MDIO, read capture.
// Ports: clk, reset_b (sync, active low), bus (slave modport), mdc, mdio_o/t/i.
module mdio_master #(
    parameter int FRAMEWIDTH = 32,
    parameter int PREAMBLE   = 32,
    parameter int RATIOWIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_b,
    mdio_master_if.slave bus,
    output logic         mdc,
    output logic         mdio_o,
    output logic         mdio_t,
    input  logic         mdio_i
);
    localparam int BMAX = (PREAMBLE > FRAMEWIDTH) ? PREAMBLE : FRAMEWIDTH;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE - 1);
    localparam logic [BW-1:0] FRM_LAST  = BW'(FRAMEWIDTH - 1);
    // frame positions (counted from the msb) of the TA and data fields
    localparam logic [BW-1:0] TA_FIRST  = BW'(FRAMEWIDTH - 18);
    localparam logic [BW-1:0] DAT_FIRST = BW'(FRAMEWIDTH - 16);

    typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [RATIOWIDTH-1:0] cnt_q, cnt_d;
    logic [RATIOWIDTH-1:0] ratio_q, ratio_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAMEWIDTH-1:0] frame_q, frame_d;
    logic                  rd_q, rd_d;
    logic                  mdc_q, mdc_d;
    logic [15:0]           sh_q, sh_d;
    logic [15:0]           rx_q, rx_d;
    logic                  wrap;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            rd_q    <= 1'b0;
            mdc_q   <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            rd_q    <= rd_d;
            mdc_q   <= mdc_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
        end
    end

    assign wrap = (cnt_q == ratio_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        rd_d    = rd_q;
        mdc_d   = mdc_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        unique case (state_q)
            IDLE: begin
                mdc_d = 1'b0;
                cnt_d = '0;
                bit_d = '0;
                if (bus.stb_mdiostart) begin
                    frame_d = bus.mdiodatatx;
                    ratio_d = bus.mdioclk4ratio;
                    rd_d    = (bus.mdiodatatx[FRAMEWIDTH-3 -: 2] == 2'b10);
                    sh_d    = '0;
                    state_d = PRE;
                end
            end
            PRE, SHIFT: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (wrap) begin
                    mdc_d = ~mdc_q;
                    if (!mdc_q) begin
                        // rising MDC: capture PHY data bits
                        if (state_q == SHIFT && rd_q &&
                            bit_q >= DAT_FIRST)
                            sh_d = {sh_q[14:0], mdio_i};
                    end else begin
                        // falling MDC: end of the bit period
                        bit_d = bit_q + 1'b1;
                        if (state_q == PRE) begin
                            if (bit_q == PRE_LAST) begin
                                bit_d   = '0;
                                state_d = SHIFT;
                            end
                        end else begin
                            frame_d = frame_q << 1;
                            if (bit_q == FRM_LAST) begin
                                rx_d    = rd_q ? sh_q : 16'h0;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                mdc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mdio_o = 1'b1;
        mdio_t = 1'b0;
        unique case (state_q)
            PRE:     mdio_t = 1'b1;
            SHIFT: begin
                mdio_o = frame_q[FRAMEWIDTH-1];
                mdio_t = !(rd_q && bit_q >= TA_FIRST);
            end
            default: ;
        endcase
    end

    assign mdc             = mdc_q;
    assign bus.busy        = (state_q == PRE) || (state_q == SHIFT);
    assign bus.mdiorxvalid = (state_q == DONE);
    assign bus.mdiodatarx  = rx_q;
endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: random frames, PHY model, reset cases.
// Expected frames are queued at strobe time and retired on mdiorxvalid.
module tb_mdio_master;
    typedef struct {
        int          s;
        int          done;
        int          r;
        logic [31:0] w;
        logic        rd;
        logic [15:0] rx;
    } fr_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic mdc, mdio_o, mdio_t;
    logic mdio_i = 1'b1;

    mdio_master_if #(.FRAMEWIDTH(32), .RATIOWIDTH(8)) bus ();

    mdio_master dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus),
        .mdc     (mdc),
        .mdio_o  (mdio_o),
        .mdio_t  (mdio_t),
        .mdio_i  (mdio_i)
    );

    always #5 clk = ~clk;

    fr_t         q[$];
    int          ncyc = 0;
    int          last_done = 0;
    int          last_s = 0;
    logic [15:0] last_rx = 16'h0;
    int          tests = 0;
    int          fails = 0;
    int          wave_err = 0;
    int          wave_cyc = 0;
    logic [3:0]  wave_got, wave_exp;
    int          idle_err = 0;
    int          idle_cyc = 0;

    function automatic void chk(input string n, input logic [31:0] a,
                                input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, a, x);
        end
    endfunction

    function automatic void wave_chk(input int s);
        tests++;
        if (wave_err != 0) begin
            fails++;
            $display("FAIL wave(S=%0d): %0d bad cycles, first at %0d got busy,mdc,t,o=%b want %b",
                     s, wave_err, wave_cyc, wave_got, wave_exp);
        end
        wave_err = 0;
    endfunction

    // Monitor / PHY model: sampled mid-cycle on the falling clk edge.
    initial begin
        int k, hp, bitn, idx;
        logic em, et, eo, bad;
        fr_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            mdio_i = 1'b1;
            if (q.size() > 0 && ncyc > q[0].s && ncyc <= q[0].done) begin
                em = 1'b0;
                et = 1'b0;
                eo = 1'b1;
                if (ncyc < q[0].done) begin
                    hp   = q[0].r + 1;
                    k    = ncyc - q[0].s - 1;
                    bitn = k / (2 * hp);
                    em   = (k % (2 * hp)) >= hp;
                    et   = 1'b1;
                    if (bitn >= 32) begin
                        idx = 63 - bitn;
                        et  = !(q[0].rd && idx <= 17);
                        eo  = q[0].w[idx];
                        if (q[0].rd && idx == 16)
                            mdio_i = 1'b0;
                        else if (q[0].rd && idx <= 15)
                            mdio_i = q[0].rx[idx];
                    end
                    bad = bus.busy !== 1'b1 || mdc !== em ||
                          mdio_t !== et || (et && mdio_o !== eo) ||
                          bus.mdiorxvalid !== 1'b0;
                    wave_exp = {1'b1, em, et, eo};
                end else begin
                    bad = bus.busy !== 1'b0 || mdc !== 1'b0 ||
                          mdio_t !== 1'b0;
                    wave_exp = {1'b0, 1'b0, 1'b0, mdio_o};
                end
                if (bad) begin
                    if (wave_err == 0) begin
                        wave_cyc = ncyc;
                        wave_got = {bus.busy, mdc, mdio_t, mdio_o};
                    end
                    wave_err++;
                end
            end else if (bus.busy !== 1'b0 || mdc !== 1'b0 ||
                         mdio_t !== 1'b0 || bus.mdiodatarx !== last_rx) begin
                if (idle_err == 0) idle_cyc = ncyc;
                idle_err++;
            end
            if (bus.mdiorxvalid === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: at cycle %0d", ncyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", ncyc, e.done);
                    chk("rx_data", {16'h0, bus.mdiodatarx}, {16'h0, e.rx});
                    wave_chk(e.s);
                    last_rx = e.rx;
                end
            end else if (q.size() > 0 && ncyc >= q[0].done) begin
                tests++;
                fails++;
                $display("FAIL missing_pulse: frame S=%0d want pulse at %0d",
                         q[0].s, q[0].done);
                e = q.pop_front();
                wave_err = 0;
            end
        end
    end

    // Called at posedge+1: the strobe is sampled at the end of cycle ncyc+1.
    task automatic strobe(input logic [31:0] w, input int r,
                          input logic [15:0] phy);
        fr_t e;
        int  s;
        s = ncyc + 1;
        bus.stb_mdiostart = 1'b1;
        bus.mdiodatatx    = w;
        bus.mdioclk4ratio = r[7:0];
        if (s > last_done) begin
            e.s    = s;
            e.r    = r;
            e.w    = w;
            e.rd   = (w[29:28] == 2'b10);
            e.rx   = e.rd ? phy : 16'h0;
            e.done = s + 1 + (32 + 32) * 2 * (r + 1);
            q.push_back(e);
            last_done = e.done;
            last_s    = s;
        end
        @(posedge clk);
        #1;
        bus.stb_mdiostart = 1'b0;
        bus.mdiodatatx    = $urandom;
        bus.mdioclk4ratio = 8'($urandom);
    endtask

    task automatic wait_cycle(input int c);
        while (ncyc + 1 < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic with_stb);
        int s;
        s = ncyc + 1;
        reset_b = 1'b0;
        if (with_stb) begin
            bus.stb_mdiostart = 1'b1;
            bus.mdiodatatx    = 32'h6000_0000;
            bus.mdioclk4ratio = 8'd0;
        end
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        bus.stb_mdiostart = 1'b0;
        if (q.size() > 0) wave_chk(q[0].s);
        q.delete();
        wave_err  = 0;
        last_done = s;
        last_rx   = 16'h0;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_mdc", {31'h0, mdc}, 32'h0);
        chk("rst_mdio_t", {31'h0, mdio_t}, 32'h0);
        chk("rst_mdio_o", {31'h0, mdio_o}, 32'h1);
        chk("rst_rxvalid", {31'h0, bus.mdiorxvalid}, 32'h0);
        chk("rst_rx", {16'h0, bus.mdiodatarx}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int          r;
        bus.stb_mdiostart = 1'b0;
        bus.mdiodatatx    = '0;
        bus.mdioclk4ratio = '0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b0);

        wait_cycle(10);
        strobe(32'h5096_A5C3, 0, 16'h0);

        wait_cycle(last_done + 1);
        strobe(32'h6000_0000, 1, 16'hBEEF);

        wait_cycle(last_done + 2);
        strobe($urandom, 3, 16'h0);
        wait_cycle(last_s + 100);
        strobe($urandom, 0, 16'h0);
        wait_cycle(last_done);
        strobe($urandom, 0, 16'h0);
        strobe(32'h6AB0_0000, 0, 16'($urandom) | 16'h8001);

        wait_cycle(last_done + 3);
        strobe(32'h6123_4567, 0, 16'h1234);
        wait_cycle(last_s + 1 + 40 * 2);
        do_reset(1'b0);

        wait_cycle(last_done + 2);
        strobe(32'h6C00_0000, 0, 16'hA55A);
        wait_cycle(last_done + 2);
        do_reset(1'b1);
        @(posedge clk);
        #1;
        chk("rst_stb_busy", {31'h0, bus.busy}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 3);
            w = $urandom;
            w[29:28] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            wait_cycle(last_done + 1 + $urandom_range(0, 3));
            strobe(w, r, 16'($urandom));
        end

        wait_cycle(last_done + 6);
        chk("queue_empty", q.size(), 0);
        tests++;
        if (idle_err != 0) begin
            fails++;
            $display("FAIL idle_state: %0d bad cycles, first at %0d",
                     idle_err, idle_cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
